pio_cpl_sched: RTL and testbench
================================

Name: pio_cpl_sched

Overview:
- Shares the single TX completion engine between NUM_REQ completion requesters, e.g. BAR0/BAR1 RX handlers and a message responder.
- Grants one requester at a time, round-robin, and issues a one-cycle compl-request to the TX engine.
- Holds the grant until the TX engine reports compl-done.
- Owns the PCIe turnoff handshake: turnoff-OK is given only when no completion is in flight.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 1024, cycles to wait for compl-done before abort (used only with the optional feature)
- CNT_W, 16, width of the completed-transfer counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_i  in  NUM_REQ  per-requester completion request; level, held until granted
- gnt_o  out  NUM_REQ  one-hot grant pulse, one cycle
- active_idx_o  out  $clog2(NUM_REQ)  index of the requester currently owning the TX engine
- tx_req_compl_o  out  1  one-cycle request pulse to the TX engine
- tx_compl_done_i  in  1  one-cycle done pulse from the TX engine
- busy_o  out  1  high while a completion is in flight
- cfg_to_turnoff_n  in  1  core turnoff request, active-low
- cfg_turnoff_ok_n  out  1  turnoff acknowledge, active-low, registered
- cpl_cnt_o  out  CNT_W  count of completed transfers, wraps
- err_o  out  1  sticky error flag

Behaviour:
- Reset values: FSM=IDLE, gnt_o=0, tx_req_compl_o=0, busy_o=0, active_idx_o=0, cfg_turnoff_ok_n=1, cpl_cnt_o=0, err_o=0, round-robin pointer=NUM_REQ-1 (requester 0 wins first).
- Reset asserted mid-transfer returns the block to reset values on the next edge. Any in-flight done pulse is lost.
- FSM states: IDLE, WAIT, OFF.
- IDLE:
  - If cfg_to_turnoff_n=0, go to OFF. Turnoff has priority over pending requests.
  - Else if |req_i, the arbiter picks the winner: first set bit searching from pointer+1, modulo NUM_REQ.
  - On that same edge: gnt_o[winner]=1 and tx_req_compl_o=1 for exactly one cycle; active_idx_o=winner; pointer=winner; busy_o=1; go to WAIT.
  - Latency from req_i high in IDLE to gnt_o/tx_req_compl_o high is 1 cycle.
- WAIT:
  - No new grants. req_i is ignored.
  - On tx_compl_done_i=1: cpl_cnt_o+1 (wraps at 2^CNT_W), busy_o=0, go to IDLE.
  - Minimum spacing between grants is therefore 2 cycles (done cycle, then IDLE decision).
  - A turnoff request during WAIT does not abort the transfer. cfg_turnoff_ok_n stays 1 until done; IDLE then moves to OFF.
- OFF:
  - cfg_turnoff_ok_n=0, registered, so it is low on the cycle after entry.
  - No grants.
  - When cfg_to_turnoff_n returns to 1: cfg_turnoff_ok_n=1 on the next edge, go to IDLE.
- cfg_turnoff_ok_n is 0 if and only if the state is OFF. It is never 0 while busy_o=1.
- Invariants: gnt_o is one-hot or zero; tx_req_compl_o equals |gnt_o.
- tx_compl_done_i outside WAIT is spurious: the pulse is ignored, err_o is set, and the counter is unchanged.
- Simultaneous done and turnoff in WAIT: done is taken, go to IDLE, then OFF on the following edge.
- A requester whose req_i falls before it is granted is simply skipped. No grant is ever issued to a low req_i bit.

Optional Feature:
- Macro: PIO_CPL_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter is cleared on WAIT entry.
  - If TIMEOUT_CYC cycles pass with no done: err_o is set, busy_o=0, go to IDLE, and the counter is not incremented.
  - A late done arriving after the abort is treated as spurious.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - err_o reports only spurious done pulses.

Decomposition:
- Package pio_cpl_pkg holds:
  - the state enum typedef (IDLE/WAIT/OFF);
  - the localparam for default TIMEOUT_CYC;
  - the index-width helper function.
- One sub-module, pio_rr_arb:
  - parameterised combinational round-robin pick;
  - inputs: req vector and pointer; outputs: valid, winner index, one-hot.
- The pointer register and the FSM stay in the top module.

Test Plan:
- Single request: req_i=4'b0100 in IDLE -> gnt_o=4'b0100 and tx_req_compl_o=1 on the next cycle; busy_o=1 until done; cpl_cnt_o=1 after done.
- Round-robin fairness: req_i=4'b1111 held, done 3 cycles after each grant -> grant order 0,1,2,3,0; no requester granted twice before all four are served.
- Turnoff during transfer: grant to requester 1, then cfg_to_turnoff_n=0 -> cfg_turnoff_ok_n stays 1 until done. It goes to 0 two edges after done, and no grants are issued while it is 0. Raising cfg_to_turnoff_n -> ok_n=1 and grants resume.
- Turnoff with requests pending: cfg_to_turnoff_n=0 and req_i=4'b0011 in IDLE -> OFF entered, gnt_o stays 0, ok_n=0 on the next cycle.
- Spurious done: tx_compl_done_i pulse in IDLE -> err_o=1 (sticky), cpl_cnt_o unchanged. Then a reset pulse -> all outputs return to reset values.
- With PIO_CPL_TIMEOUT_EN and TIMEOUT_CYC=16: grant with no done -> after 16 WAIT cycles err_o=1, busy_o=0, next request granted normally.

Source files
------------

// File: rtl/pio_cpl_pkg.sv
// rtl/pio_cpl_pkg.sv - shared types and helpers for the PIO completion scheduler
//
// Holds the scheduler FSM state type, the default compl-done timeout and the
// helper that sizes requester/counter index fields.
package pio_cpl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int TIMEOUT_CYC_DEF = 1024;

  // Width of an index able to address n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pio_cpl_sched_if.sv
// rtl/pio_cpl_sched_if.sv - requester and TX-engine handshake bundle
//
// Signals:
//   req_i           requester -> scheduler, per-requester level request
//   gnt_o           scheduler -> requesters, one-hot one-cycle grant
//   active_idx_o    scheduler -> TX path, index of current owner
//   tx_req_compl_o  scheduler -> TX engine, one-cycle completion request
//   tx_compl_done_i TX engine -> scheduler, one-cycle done pulse
// Modports: slave = scheduler side, master = requester/TX-engine side.
interface pio_cpl_sched_if #(
  parameter int NUM_REQ = 4
);
  import pio_cpl_pkg::*;

  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IW-1:0]      active_idx_o;
  logic               tx_req_compl_o;
  logic               tx_compl_done_i;

  modport slave (
    input  req_i, tx_compl_done_i,
    output gnt_o, active_idx_o, tx_req_compl_o
  );

  modport master (
    output req_i, tx_compl_done_i,
    input  gnt_o, active_idx_o, tx_req_compl_o
  );

endinterface

// File: rtl/pio_rr_arb.sv
// rtl/pio_rr_arb.sv - combinational round-robin pick over a request vector
//
// Ports:
//   req_i     request vector
//   ptr_i     index of the last winner; search starts at ptr_i+1 (mod NUM_REQ)
//   valid_o   at least one request is set
//   idx_o     winner index (0 when no request)
//   onehot_o  winner as a one-hot vector (0 when no request)
module pio_rr_arb
  import pio_cpl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  // One extra bit so ptr+offset never overflows before the modulo fold.
  logic [IW:0] cand;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!valid_o && req_i[cand[IW-1:0]]) begin
        valid_o                  = 1'b1;
        idx_o                    = cand[IW-1:0];
        onehot_o[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_cpl_sched.sv
// rtl/pio_cpl_sched.sv - round-robin owner of the TX completion engine with turnoff handshake
//
// Optional feature: define PIO_CPL_TIMEOUT_EN to abort a completion that sees
// no compl-done within TIMEOUT_CYC cycles.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       req_i / gnt_o / active_idx_o / tx_req_compl_o / tx_compl_done_i
//   busy_o            completion in flight
//   cfg_to_turnoff_n  turnoff request (active-low)
//   cfg_turnoff_ok_n  turnoff acknowledge (active-low, registered)
//   cpl_cnt_o         completed-transfer count, wraps
//   err_o             sticky error: spurious done or timeout abort
module pio_cpl_sched
  import pio_cpl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pio_cpl_sched_if.slave   bus,
  output logic             busy_o,
  input  logic             cfg_to_turnoff_n,
  output logic             cfg_turnoff_ok_n,
  output logic [CNT_W-1:0] cpl_cnt_o,
  output logic             err_o
);

  localparam int IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("pio_cpl_sched: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               okn_q, okn_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               arb_valid;
  logic [IW-1:0]      arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;

`ifdef PIO_CPL_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT_CYC);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          timeout;
  assign timeout = (wcnt_q == TW'(TIMEOUT_CYC - 1));
`endif

  pio_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i    (bus.req_i),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .idx_o    (arb_idx),
    .onehot_o (arb_onehot)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef PIO_CPL_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif

    case (state_q)
      IDLE: begin
        // Turnoff wins over pending requests.
        if (!cfg_to_turnoff_n) begin
          state_d = OFF;
        end else if (arb_valid) begin
          gnt_d   = arb_onehot;
          idx_d   = arb_idx;
          ptr_d   = arb_idx;
          busy_d  = 1'b1;
          state_d = WAIT;
`ifdef PIO_CPL_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end
        if (bus.tx_compl_done_i) err_d = 1'b1;
      end

      WAIT: begin
        // Turnoff is deliberately not looked at here: the transfer finishes first.
        if (bus.tx_compl_done_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef PIO_CPL_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
`endif
      end

      OFF: begin
        if (cfg_to_turnoff_n) state_d = IDLE;
        if (bus.tx_compl_done_i) err_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // Derived from the next state so the acknowledge is low exactly while in OFF.
    okn_d = (state_d != OFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      okn_q   <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef PIO_CPL_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      okn_q   <= okn_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef PIO_CPL_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign bus.gnt_o          = gnt_q;
  assign bus.tx_req_compl_o = |gnt_q;
  assign bus.active_idx_o   = idx_q;
  assign busy_o             = busy_q;
  assign cfg_turnoff_ok_n   = okn_q;
  assign cpl_cnt_o          = cnt_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_pio_cpl_sched.sv
// tb/tb_pio_cpl_sched.sv - self-checking bench for pio_cpl_sched
module tb_pio_cpl_sched;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        to_n = 1'b1;
  logic        ok_n;
  logic        busy;
  logic        err;
  logic [15:0] cnt;

  pio_cpl_sched_if #(.NUM_REQ(N)) bus();

  pio_cpl_sched #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (16),
    .CNT_W       (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .busy_o           (busy),
    .cfg_to_turnoff_n (to_n),
    .cfg_turnoff_ok_n (ok_n),
    .cpl_cnt_o        (cnt),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t        vt [8];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  sb [$];
  int          m_ptr = 3;
  logic [15:0] m_cnt = '0;
  logic [3:0]  served;
  logic [3:0]  tmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return 0;
  endfunction

  // Reference round-robin: first set bit after the last winner.
  function automatic logic [3:0] predict(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + 1 + k) % N;
      if (r[c]) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  // Runs every cycle: compares any observed grant against the scoreboard.
  task automatic monitor();
    logic [3:0] e;
    chk("tx_req_eq_or_gnt", 32'(bus.tx_req_compl_o), 32'(|bus.gnt_o));
    if (ok_n == 1'b0) chk("busy_while_ok_low", 32'(busy), 32'd0);
    if (bus.gnt_o != 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b, expected none", bus.gnt_o);
      end else begin
        e = sb.pop_front();
        chk("grant", 32'(bus.gnt_o), 32'(e));
        chk("active_idx", 32'(bus.active_idx_o), 32'(onehot_idx(e)));
        m_ptr = onehot_idx(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic pulse_done();
    bus.tx_compl_done_i = 1'b1;
    step();
    bus.tx_compl_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.tx_compl_done_i = 1'b0;
    to_n = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_ptr = 3;
    m_cnt = '0;
    sb.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_tx_req", 32'(bus.tx_req_compl_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(bus.active_idx_o), 32'd0);
    chk("rst_ok_n", 32'(ok_n), 32'd1);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  task automatic wait_gnt(input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.gnt_o == 4'b0000 && n < bound);
    if (bus.gnt_o == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant in %0d cycles, expected a grant", bound);
    end
  endtask

  initial begin
    bus.req_i = '0;
    bus.tx_compl_done_i = 1'b0;

    do_reset();
    check_reset_vals();

    // Single-requester transactions; pointer walk starts at 3 after reset.
    vt[0] = '{4'b0100, 4'b0100};
    vt[1] = '{4'b0011, 4'b0001};
    vt[2] = '{4'b0011, 4'b0010};
    vt[3] = '{4'b1001, 4'b1000};
    vt[4] = '{4'b1001, 4'b0001};
    vt[5] = '{4'b0001, 4'b0001};
    vt[6] = '{4'b1110, 4'b0010};
    vt[7] = '{4'b1100, 4'b0100};
    for (int i = 0; i < 8; i++) begin
      bus.req_i = vt[i].req;
      sb.push_back(vt[i].gnt);
      step();
      bus.req_i = '0;
      chk("grant_consumed", 32'(sb.size()), 32'd0);
      chk("busy_after_grant", 32'(busy), 32'd1);
      step();
      step();
      chk("busy_in_wait", 32'(busy), 32'd1);
      pulse_done();
      m_cnt++;
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("cnt_after_done", 32'(cnt), 32'(m_cnt));
      chk("err_clean", 32'(err), 32'd0);
    end

    // Fairness with all requesters held.
    do_reset();
    bus.req_i = 4'b1111;
    served = '0;
    for (int i = 0; i < 5; i++) begin
      tmp = 4'(1 << (i % 4));
      sb.push_back(tmp);
      wait_gnt(8);
      if (i < 4) served = served | bus.gnt_o;
      if (i == 3) chk("all_served_once", 32'(served), 32'hf);
      step();
      step();
      pulse_done();
      m_cnt++;
    end
    bus.req_i = '0;
    chk("fair_cnt", 32'(cnt), 32'(m_cnt));

    // Turnoff requested while a completion is in flight.
    bus.req_i = 4'b0010;
    sb.push_back(predict(4'b0010, m_ptr));
    step();
    bus.req_i = '0;
    to_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ok_n_held_in_wait", 32'(ok_n), 32'd1);
      chk("busy_held_in_wait", 32'(busy), 32'd1);
    end
    pulse_done();
    m_cnt++;
    chk("ok_n_at_done", 32'(ok_n), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    bus.req_i = 4'b1111;
    step();
    chk("ok_n_two_after_done", 32'(ok_n), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ok_n_in_off", 32'(ok_n), 32'd0);
    end
    to_n = 1'b1;
    step();
    chk("ok_n_release", 32'(ok_n), 32'd1);
    sb.push_back(predict(4'b1111, m_ptr));
    step();
    bus.req_i = '0;
    chk("grant_resumed", 32'(sb.size()), 32'd0);
    step();
    pulse_done();
    m_cnt++;

    // Turnoff takes priority over pending requests in IDLE.
    to_n = 1'b0;
    bus.req_i = 4'b0011;
    step();
    chk("ok_n_pending", 32'(ok_n), 32'd0);
    chk("no_gnt_pending", 32'(bus.gnt_o), 32'd0);
    step();
    chk("ok_n_pending_hold", 32'(ok_n), 32'd0);
    to_n = 1'b1;
    bus.req_i = '0;
    step();
    chk("ok_n_pending_release", 32'(ok_n), 32'd1);

    // A grant that never sees its done pulse.
    bus.req_i = 4'b1000;
    sb.push_back(predict(4'b1000, m_ptr));
    step();
    bus.req_i = '0;
`ifdef PIO_CPL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    chk("busy_before_timeout", 32'(busy), 32'd1);
    step();
    chk("busy_after_timeout", 32'(busy), 32'd0);
    chk("err_after_timeout", 32'(err), 32'd1);
    chk("cnt_after_timeout", 32'(cnt), 32'(m_cnt));
    pulse_done();
    chk("cnt_late_done", 32'(cnt), 32'(m_cnt));
    bus.req_i = 4'b0001;
    sb.push_back(predict(4'b0001, m_ptr));
    step();
    bus.req_i = '0;
    pulse_done();
    m_cnt++;
    chk("cnt_after_timeout_recover", 32'(cnt), 32'(m_cnt));
`else
    for (int i = 0; i < 40; i++) step();
    chk("busy_no_timeout", 32'(busy), 32'd1);
    chk("err_no_timeout", 32'(err), 32'd0);
    pulse_done();
    m_cnt++;
    chk("busy_long_done", 32'(busy), 32'd0);
    chk("cnt_long_done", 32'(cnt), 32'(m_cnt));
`endif

    // Spurious done in IDLE.
    pulse_done();
    chk("err_spurious", 32'(err), 32'd1);
    chk("cnt_spurious", 32'(cnt), 32'(m_cnt));
    step();
    chk("err_sticky", 32'(err), 32'd1);

    // Reset clears everything.
    do_reset();
    check_reset_vals();

    // Reset mid-transfer; the done pulse arriving with reset is lost.
    bus.req_i = 4'b1111;
    sb.push_back(4'b0001);
    step();
    bus.req_i = '0;
    step();
    rst = 1'b1;
    bus.tx_compl_done_i = 1'b1;
    step();
    rst = 1'b0;
    bus.tx_compl_done_i = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_ok_n", 32'(ok_n), 32'd1);
    step();
    chk("mid_rst_cnt_hold", 32'(cnt), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
